i2c_slave_ctrl: RTL and testbench



---
 rtl/i2c_slave_ctrl.sv | 275 +++++++++++++++++++++++++++
 tb/tb_i2c_slave_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_ctrl.sv
// -----------------------------------------------------------------------------
// i2c_slave_ctrl
//
// Bit-level I2C slave transaction controller. It synchronises SCL/SDA,
// assembles the address byte for the external address/start-stop decoder,
// consumes the decoder's start/stop/match results, and sequences the
// address ACK, receive-byte and transmit-byte phases. SDA is open-drain:
// sda_out = 0 pulls the line low, sda_out = 1 releases it.
//
// Optional feature: define I2C_TIMEOUT_EN to add a stuck-SCL abort counter.
// Without it bus_timeout is tied low and a stuck bus waits for start/stop.
//
// Parameters:
//   TIMEOUT_CYCLES  clk cycles of unchanged SCL before abort (16..65535),
//                   only used with I2C_TIMEOUT_EN
//
// Ports:
//   clk, n_rst      system clock, asynchronous active-low reset
//   scl, sda_in     raw bus lines
//   start_found     start-condition pulse from decoder (also repeated start)
//   stop_found      stop-condition pulse from decoder
//   address_match   decoder: starting_byte matches a device address
//   rw_mode         decoder: 1 = master read, 0 = master write
//   rx_ready        consumer can accept a received byte
//   tx_data         byte to transmit, sampled in the tx_load cycle
//   starting_byte   captured address byte, to decoder
//   rx_data         last received data byte
//   rx_valid        one-cycle pulse: rx_data updated
//   tx_load         one-cycle pulse: tx_data sampled at the end of this cycle
//   sda_out         0 = pull SDA low, 1 = release
//   busy            high in any state other than IDLE
//   bus_timeout     one-cycle abort pulse
//   fsm_state       debug view of the state: 0 IDLE, 1 ADDR, 2 ADDR_ACK,
//                   3 RX, 4 RX_ACK, 5 TX, 6 TX_MACK, 7 IGNORE
//
// Handshakes: rx_valid and tx_load are single-cycle strobes with no
// back-pressure. rx_ready is only looked at on the ACK-slot SCL fall of a
// received byte, where it selects ACK (accept) or NACK (abandon transfer).
// -----------------------------------------------------------------------------
module i2c_slave_ctrl #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       scl,
    input  logic       sda_in,
    input  logic       start_found,
    input  logic       stop_found,
    input  logic       address_match,
    input  logic       rw_mode,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    output logic [7:0] starting_byte,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_load,
    output logic       sda_out,
    output logic       busy,
    output logic       bus_timeout,
    output logic [2:0] fsm_state
);

    if (TIMEOUT_CYCLES < 16 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range
        $error("i2c_slave_ctrl: TIMEOUT_CYCLES must be within 16..65535");
    end

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        RX       = 3'd3,
        RX_ACK   = 3'd4,
        TX       = 3'd5,
        TX_MACK  = 3'd6,
        IGNORE   = 3'd7
    } state_t;

    state_t state;
    state_t next_state;

    // Same synchroniser depth as the decoder so our edge strobes line up
    // cycle-for-cycle with start_found/stop_found.
    logic scl_s1, scl_s2, scl_s3;
    logic sda_s1, sda_s2;
    logic scl_rise, scl_fall, sda_bit;

    logic [2:0] bit_cnt;
    logic       byte_full;   // 8 bits shifted in, waiting for the ACK-slot fall
    logic [7:0] shift_sr;    // receive shifter (address and data)
    logic [7:0] tx_sr;       // transmit shifter, MSB is the next bit to present
    logic       mack_seen;   // master ACKed the byte just sent
    logic       timeout_hit;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_s3 <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
        end else begin
            scl_s1 <= scl;
            scl_s2 <= scl_s1;
            scl_s3 <= scl_s2;
            sda_s1 <= sda_in;
            sda_s2 <= sda_s1;
        end
    end

    assign scl_rise = scl_s2 & ~scl_s3;
    assign scl_fall = ~scl_s2 & scl_s3;
    assign sda_bit  = sda_s2;

`ifdef I2C_TIMEOUT_EN
    logic [15:0] to_cnt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            to_cnt <= '0;
        end else if (state == IDLE || scl_rise || scl_fall) begin
            to_cnt <= '0;
        end else if (!timeout_hit) begin
            to_cnt <= to_cnt + 16'd1;
        end
    end

    assign timeout_hit = (state != IDLE) && (to_cnt == 16'(TIMEOUT_CYCLES));
`else
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: stop beats start beats timeout beats SCL edges.
    always_comb begin
        next_state = state;
        if (stop_found) begin
            next_state = IDLE;
        end else if (start_found) begin
            next_state = ADDR;
        end else if (timeout_hit) begin
            next_state = IDLE;
        end else begin
            case (state)
                ADDR:     if (scl_fall && byte_full)
                              next_state = address_match ? ADDR_ACK : IGNORE;
                ADDR_ACK: if (scl_fall)
                              next_state = rw_mode ? TX : RX;
                RX:       if (scl_fall && byte_full)
                              next_state = rx_ready ? RX_ACK : IGNORE;
                RX_ACK:   if (scl_fall)
                              next_state = RX;
                TX:       if (scl_fall && bit_cnt == 3'd7)
                              next_state = TX_MACK;
                TX_MACK: begin
                    if (scl_rise && sda_bit)
                        next_state = IGNORE;
                    else if (scl_fall && mack_seen)
                        next_state = TX;
                end
                default: ;
            endcase
        end
    end

    // Output logic. tx_load fires in the strobe cycle of every entry into TX,
    // so tx_data is captured on the same edge that drives bit 7 onto SDA.
    always_comb begin
        busy        = (state != IDLE);
        tx_load     = (next_state == TX) && (state != TX);
        bus_timeout = timeout_hit && !stop_found && !start_found;
        fsm_state   = state;
    end

    // Datapath: shifters, bit counter and the registered SDA driver. SDA only
    // changes on the edge after an scl_fall strobe, keeping it stable while
    // SCL is high.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sda_out       <= 1'b1;
            starting_byte <= 8'h00;
            rx_data       <= 8'h00;
            rx_valid      <= 1'b0;
            bit_cnt       <= 3'd0;
            byte_full     <= 1'b0;
            shift_sr      <= 8'h00;
            tx_sr         <= 8'h00;
            mack_seen     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (stop_found || start_found || timeout_hit) begin
                sda_out   <= 1'b1;
                bit_cnt   <= 3'd0;
                byte_full <= 1'b0;
                mack_seen <= 1'b0;
            end else begin
                case (state)
                    ADDR, RX: begin
                        if (scl_rise && !byte_full) begin
                            shift_sr <= {shift_sr[6:0], sda_bit};
                            if (bit_cnt == 3'd7) begin
                                bit_cnt   <= 3'd0;
                                byte_full <= 1'b1;
                                if (state == ADDR) begin
                                    starting_byte <= {shift_sr[6:0], sda_bit};
                                end else begin
                                    rx_data  <= {shift_sr[6:0], sda_bit};
                                    rx_valid <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end else if (scl_fall && byte_full) begin
                            byte_full <= 1'b0;
                            // ACK (pull low) only when the byte is accepted
                            sda_out <= !(next_state == ADDR_ACK || next_state == RX_ACK);
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (rw_mode) begin
                                sda_out <= tx_data[7];
                                tx_sr   <= {tx_data[6:0], 1'b0};
                                bit_cnt <= 3'd0;
                            end else begin
                                sda_out <= 1'b1;
                            end
                        end
                    end
                    RX_ACK: begin
                        if (scl_fall) begin
                            sda_out <= 1'b1;
                            bit_cnt <= 3'd0;
                        end
                    end
                    TX: begin
                        if (scl_fall) begin
                            if (bit_cnt == 3'd7) begin
                                // bit 0 has been on the bus; free SDA for the master ACK
                                sda_out   <= 1'b1;
                                bit_cnt   <= 3'd0;
                                mack_seen <= 1'b0;
                            end else begin
                                sda_out <= tx_sr[7];
                                tx_sr   <= {tx_sr[6:0], 1'b0};
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    TX_MACK: begin
                        if (scl_rise && !sda_bit) begin
                            mack_seen <= 1'b1;
                        end else if (scl_fall && mack_seen) begin
                            mack_seen <= 1'b0;
                            sda_out   <= tx_data[7];
                            tx_sr     <= {tx_data[6:0], 1'b0};
                            bit_cnt   <= 3'd0;
                        end
                    end
                    default: begin
                        sda_out <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// -----------------------------------------------------------------------------
// tb_i2c_slave_ctrl
//
// Bench acting as I2C master, address decoder (device address 7'h21) and
// register-file side for i2c_slave_ctrl. A transaction-level model decides,
// for every SCL-high slot, what the slave must put on SDA, and which bytes
// must appear on rx_data / be fetched via tx_load.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2c_slave_ctrl;

    localparam logic [6:0] DEV_ADDR  = 7'h21;
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_IGNORE = 3'd7;
`ifdef I2C_TIMEOUT_EN
    localparam int TO_CYCLES = 100;
`else
    localparam int TO_CYCLES = 65535;
`endif

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic       scl         = 1'b1;
    logic       sda_m       = 1'b1;   // master's open-drain drive
    logic       start_found = 1'b0;
    logic       stop_found  = 1'b0;
    logic       rx_ready    = 1'b1;
    logic [7:0] tx_data     = 8'h00;
    logic       sda_in;
    logic       address_match;
    logic       rw_mode;
    logic [7:0] starting_byte;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_load;
    logic       sda_out;
    logic       busy;
    logic       bus_timeout;
    logic [2:0] fsm_state;

    assign sda_in        = sda_m & sda_out;
    assign address_match = (starting_byte[7:1] == DEV_ADDR);
    assign rw_mode       = starting_byte[0];

    i2c_slave_ctrl #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .scl           (scl),
        .sda_in        (sda_in),
        .start_found   (start_found),
        .stop_found    (stop_found),
        .address_match (address_match),
        .rw_mode       (rw_mode),
        .rx_ready      (rx_ready),
        .tx_data       (tx_data),
        .starting_byte (starting_byte),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .tx_load       (tx_load),
        .sda_out       (sda_out),
        .busy          (busy),
        .bus_timeout   (bus_timeout),
        .fsm_state     (fsm_state)
    );

    // ---------------- scoreboard state ----------------
    int         n_checks  = 0;
    int         n_errors  = 0;
    logic [7:0] exp_q[$];        // bytes that must appear on rx_data
    logic [7:0] tx_q[$];         // bytes the slave must fetch, in order
    int         n_rxv     = 0;
    int         exp_rxv   = 0;
    int         n_load    = 0;
    int         exp_loads = 0;
    int         n_to      = 0;
    logic       exp_sda   = 1'b1;
    logic       check_en  = 1'b0;

    logic [7:0] data_a[4];
    logic       rdy_a[4];
    logic       mack_a[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle, against the model's current expectations.
    initial begin
        forever begin
            @(negedge clk);
            if (n_rst) begin
                if (check_en) chk("sda_out", {31'd0, sda_out}, {31'd0, exp_sda});
                if (rx_valid) begin
                    n_rxv++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL rx_valid: got unexpected pulse, rx_data 0x%0h, none required", rx_data);
                    end else begin
                        chk("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
                    end
                end
`ifdef I2C_TIMEOUT_EN
                if (bus_timeout) n_to++;
`else
                chk("bus_timeout", {31'd0, bus_timeout}, 32'd0);
`endif
            end
        end
    end

    // Register-file side for reads: present queue head, advance after each load.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_load) begin
                n_load++;
                @(posedge clk);
                #1;
                if (tx_q.size() != 0) void'(tx_q.pop_front());
            end
            if (tx_q.size() != 0) tx_data = tx_q[0];
            else tx_data = 8'h00;
        end
    end

    initial begin
        #600us;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One SCL clock: master drives m during low, slave must show es while high.
    task automatic bit_slot(input logic m, input logic es, output logic bus);
        tick($urandom_range(5, 8));
        sda_m = m;
        tick(1);
        exp_sda  = es;
        check_en = 1'b1;
        scl      = 1'b1;
        tick($urandom_range(5, 8));
        bus      = sda_in;
        check_en = 1'b0;
        scl      = 1'b0;
    endtask

    task automatic do_start();
        if (scl == 1'b0) begin
            tick(6);
            sda_m = 1'b1;
            tick(2);
            exp_sda  = 1'b1;
            check_en = 1'b1;
            scl      = 1'b1;
            tick(5);
        end else begin
            sda_m = 1'b1;
            tick(2);
        end
        sda_m = 1'b0;
        tick(3);
        start_found = 1'b1;
        tick(1);
        start_found = 1'b0;
        tick(4);
        check_en = 1'b0;
        scl      = 1'b0;
    endtask

    task automatic do_stop();
        tick(6);
        sda_m = 1'b0;
        tick(2);
        exp_sda  = 1'b1;
        check_en = 1'b1;
        scl      = 1'b1;
        tick(4);
        sda_m = 1'b1;
        tick(3);
        stop_found = 1'b1;
        tick(1);
        stop_found = 1'b0;
        tick(2);
        check_en = 1'b0;
        tick(4);
    endtask

    task automatic wr_byte(input logic [7:0] b, input logic exp_ack);
        logic bus;
        for (int i = 7; i >= 0; i--) bit_slot(b[i], 1'b1, bus);
        bit_slot(1'b1, exp_ack, bus);
    endtask

    task automatic rd_byte(input logic [7:0] eb, input logic m_ack);
        logic       bus;
        logic [7:0] got;
        got = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            bit_slot(1'b1, eb[i], bus);
            got[i] = bus;
        end
        bit_slot(m_ack, 1'b1, bus);
        chk("read_byte_on_bus", {24'd0, got}, {24'd0, eb});
    endtask

    // Full transaction using data_a/rdy_a/mack_a; model derived from the
    // protocol rules: matched write => ACK while consumer is ready, matched
    // read => slave sends bytes until master NACKs, otherwise SDA released.
    task automatic xfer(input logic [7:0] addr, input int n);
        logic match, act;
        match = (addr[7:1] == DEV_ADDR);
        if (addr[0]) mack_a[n-1] = 1'b1;
        if (match && addr[0]) begin
            for (int k = 0; k < n; k++) begin
                tx_q.push_back(data_a[k]);
                exp_loads++;
                if (mack_a[k]) break;
            end
        end
        do_start();
        chk("busy_active", {31'd0, busy}, 32'd1);
        wr_byte(addr, ~match);
        act = match;
        for (int k = 0; k < n; k++) begin
            if (!addr[0]) begin
                rx_ready = rdy_a[k];
                if (act) begin
                    exp_q.push_back(data_a[k]);
                    exp_rxv++;
                end
                wr_byte(data_a[k], ~(act & rdy_a[k]));
                if (!rdy_a[k]) act = 1'b0;
            end else begin
                rd_byte(act ? data_a[k] : 8'hFF, mack_a[k]);
                if (mack_a[k]) act = 1'b0;
            end
        end
        do_stop();
        chk("busy_idle", {31'd0, busy}, 32'd0);
        chk("state_idle", {29'd0, fsm_state}, {29'd0, ST_IDLE});
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic bus;
        int   rxv0, ld0;
        logic [7:0] a;

        tick(3);
        chk("rst_sda_out", {31'd0, sda_out}, 32'd1);
        chk("rst_starting_byte", {24'd0, starting_byte}, 32'h00);
        chk("rst_rx_data", {24'd0, rx_data}, 32'h00);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_tx_load", {31'd0, tx_load}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_bus_timeout", {31'd0, bus_timeout}, 32'd0);
        chk("rst_state", {29'd0, fsm_state}, {29'd0, ST_IDLE});
        n_rst = 1'b1;
        tick(5);

        // Write 0x42 / 0xA5
        data_a[0] = 8'hA5; rdy_a[0] = 1'b1;
        xfer(8'h42, 1);
        chk("write_rx_data", {24'd0, rx_data}, 32'hA5);
        chk("write_starting_byte", {24'd0, starting_byte}, 32'h42);
        chk("write_rx_count", n_rxv, 32'd1);

        // Non-matching address 0x7E: released throughout, IGNORE until stop
        do_start();
        wr_byte(8'h7E, 1'b1);
        tick(4);
        chk("nomatch_state", {29'd0, fsm_state}, {29'd0, ST_IGNORE});
        wr_byte(8'h55, 1'b1);
        chk("nomatch_state_after", {29'd0, fsm_state}, {29'd0, ST_IGNORE});
        do_stop();
        chk("nomatch_rx_count", n_rxv, 32'd1);

        // Read 0x43: 0x3C (ACK) then 0xFF (NACK)
        ld0 = n_load;
        data_a[0] = 8'h3C; mack_a[0] = 1'b0;
        data_a[1] = 8'hFF; mack_a[1] = 1'b1;
        xfer(8'h43, 2);
        chk("read_load_count", n_load - ld0, 32'd2);

        // Repeated start after 3 data bits of a write, then read
        rxv0 = n_rxv;
        do_start();
        wr_byte(8'h42, 1'b0);
        rx_ready = 1'b1;
        bit_slot(1'b1, 1'b1, bus);
        bit_slot(1'b0, 1'b1, bus);
        bit_slot(1'b1, 1'b1, bus);
        data_a[0] = 8'h96; mack_a[0] = 1'b1;
        xfer(8'h43, 1);
        chk("rstart_no_rx", n_rxv - rxv0, 32'd0);
        chk("rstart_starting_byte", {24'd0, starting_byte}, 32'h43);

        // Consumer not ready: NACK, rx_valid still pulses, IGNORE
        do_start();
        wr_byte(8'h42, 1'b0);
        rx_ready = 1'b0;
        exp_q.push_back(8'hC3);
        exp_rxv++;
        wr_byte(8'hC3, 1'b1);
        tick(4);
        chk("notready_state", {29'd0, fsm_state}, {29'd0, ST_IGNORE});
        chk("notready_rx_data", {24'd0, rx_data}, 32'hC3);
        do_stop();
        rx_ready = 1'b1;

        // Randomised transactions
        for (int t = 0; t < 25; t++) begin
            case ($urandom_range(0, 3))
                0: a = 8'h42;
                1: a = 8'h43;
                2: begin
                    a = 8'($urandom_range(0, 255));
                    if (a[7:1] == DEV_ADDR) a[7] = ~a[7];
                end
                default: a = {DEV_ADDR, 1'($urandom_range(0, 1))};
            endcase
            for (int k = 0; k < 4; k++) begin
                data_a[k] = 8'($urandom_range(0, 255));
                rdy_a[k]  = ($urandom_range(0, 4) != 0);
                mack_a[k] = ($urandom_range(0, 3) == 0);
            end
            xfer(a, $urandom_range(1, 4));
        end

`ifdef I2C_TIMEOUT_EN
        // SCL stuck low mid-byte
        do_start();
        wr_byte(8'h42, 1'b0);
        rx_ready = 1'b1;
        bit_slot(1'b0, 1'b1, bus);
        bit_slot(1'b1, 1'b1, bus);
        bit_slot(1'b0, 1'b1, bus);
        chk("timeout_none_before", n_to, 32'd0);
        tick(130);
        chk("timeout_pulses", n_to, 32'd1);
        chk("timeout_sda_out", {31'd0, sda_out}, 32'd1);
        chk("timeout_busy", {31'd0, busy}, 32'd0);
        do_stop();
`endif

        tick(10);
        chk("rx_queue_empty", exp_q.size(), 32'd0);
        chk("rx_pulse_count", n_rxv, exp_rxv);
        chk("tx_load_count", n_load, exp_loads);
        chk("tx_queue_empty", tx_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
